// File: rtl/jzjpcc_hazard_pkg.sv
// Shared types and constants for the jzjpcc hazard controller and its scoreboard.
package jzjpcc_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE      = 2'd0,
        FWD_MEMORY    = 2'd1,
        FWD_WRITEBACK = 2'd2
    } fwd_sel_t;

    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic stall_execute;
        logic stall_memory;
        logic flush_decode;
        logic flush_execute;
        logic flush_memory;
    } pipe_ctrl_t;

endpackage

// File: rtl/jzjpcc_scoreboard.sv
// Busy-bit scoreboard for long-latency (mul/div) destinations, with a per-source
// lookup that flags any used decode operand whose register is still in flight.
module jzjpcc_scoreboard
    import jzjpcc_hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              set_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]         set_addr_i,
    input  logic                              clr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]         clr_addr_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]                src_used_i,
    output logic                              hazard_o
);

    localparam int W       = REG_ADDR_WIDTH;
    localparam int NUM_REG = 2 ** REG_ADDR_WIDTH;
    localparam logic [W-1:0] ZERO_ADDR = W'(ZERO_REG);

    logic [NUM_REG-1:0] busy_q, busy_d;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used_i[i] && (src_addr_i[i*W +: W] != ZERO_ADDR)
                    && busy_q[src_addr_i[i*W +: W]]) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jzjpcc_hazard_controller.sv
// Hazard controller for the five-stage jzjpcc pipeline: operand forwarding, load-use
// countdown stalls, long-op scoreboard stalls, memory-wait stalls and redirect flushes.
module jzjpcc_hazard_controller
    import jzjpcc_hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int NUM_SRC         = 2,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] rsAddr_decode,
    input  logic [NUM_SRC-1:0]                rsUsed_decode,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] rsAddr_execute,
    input  logic [REG_ADDR_WIDTH-1:0]         rdAddr_execute,
    input  logic [REG_ADDR_WIDTH-1:0]         rdAddr_memory,
    input  logic [REG_ADDR_WIDTH-1:0]         rdAddr_writeback,
    input  logic                              regWrite_execute,
    input  logic                              regWrite_memory,
    input  logic                              regWrite_writeback,
    input  logic                              isLoad_execute,
    input  logic                              longOpIssue_execute,
    input  logic                              longOpDone,
    input  logic [REG_ADDR_WIDTH-1:0]         longOpDoneRd,
    input  logic                              memBusy,
    input  logic                              redirect_execute,
    output logic                              stall_fetch,
    output logic                              stall_decode,
    output logic                              stall_execute,
    output logic                              stall_memory,
    output logic                              flush_decode,
    output logic                              flush_execute,
    output logic                              flush_memory,
    output logic [NUM_SRC*2-1:0]              fwdSel_execute,
    output logic [2:0]                        loadUseCount
);

    localparam int W = REG_ADDR_WIDTH;
    localparam logic [W-1:0] ZERO_ADDR = W'(ZERO_REG);
    localparam logic [2:0]   LU_RELOAD = 3'(LOAD_USE_STALLS - 1);

    logic [2:0] count_q, count_d;
    logic       load_use;
    logic       sb_hazard;
    logic       sb_set;
    logic       lu_stall;
    pipe_ctrl_t ctrl;

    always_comb begin
        load_use = 1'b0;
        if (isLoad_execute && regWrite_execute && (rdAddr_execute != ZERO_ADDR)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rsUsed_decode[i] && (rsAddr_decode[i*W +: W] == rdAddr_execute)) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // The detect cycle itself is the first stall, so the counter covers the remaining ones.
    always_comb begin
        count_d = count_q;
        if (redirect_execute) begin
            count_d = 3'd0;
        end else if (memBusy) begin
            count_d = count_q;
        end else if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
        end else if (load_use) begin
            count_d = LU_RELOAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign lu_stall     = load_use || (count_q != 3'd0);
    assign loadUseCount = count_q;

    assign sb_set = longOpIssue_execute && regWrite_execute && (rdAddr_execute != ZERO_ADDR)
                    && !memBusy && !redirect_execute;

    jzjpcc_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_SRC        (NUM_SRC)
    ) u_scoreboard (
        .clk_i      (clock),
        .rst_i      (reset),
        .set_en_i   (sb_set),
        .set_addr_i (rdAddr_execute),
        .clr_en_i   (longOpDone),
        .clr_addr_i (longOpDoneRd),
        .src_addr_i (rsAddr_decode),
        .src_used_i (rsUsed_decode),
        .hazard_o   (sb_hazard)
    );

    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl.flush_decode  = 1'b1;
            ctrl.flush_execute = 1'b1;
            ctrl.flush_memory  = 1'b1;
        end else if (memBusy) begin
            ctrl.stall_fetch   = 1'b1;
            ctrl.stall_decode  = 1'b1;
            ctrl.stall_execute = 1'b1;
            ctrl.stall_memory  = 1'b1;
        end else if (redirect_execute) begin
            ctrl.flush_decode  = 1'b1;
            ctrl.flush_execute = 1'b1;
        end else if (lu_stall || sb_hazard) begin
            ctrl.stall_fetch   = 1'b1;
            ctrl.stall_decode  = 1'b1;
            ctrl.flush_execute = 1'b1;
        end
    end

    assign stall_fetch   = ctrl.stall_fetch;
    assign stall_decode  = ctrl.stall_decode;
    assign stall_execute = ctrl.stall_execute;
    assign stall_memory  = ctrl.stall_memory;
    assign flush_decode  = ctrl.flush_decode;
    assign flush_execute = ctrl.flush_execute;
    assign flush_memory  = ctrl.flush_memory;

    // Memory stage holds the younger result, so it beats writeback.
    always_comb begin
        fwdSel_execute = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!reset && (rsAddr_execute[i*W +: W] != ZERO_ADDR)) begin
                if (regWrite_memory && (rdAddr_memory == rsAddr_execute[i*W +: W])) begin
                    fwdSel_execute[i*2 +: 2] = FWD_MEMORY;
                end else if (regWrite_writeback
                             && (rdAddr_writeback == rsAddr_execute[i*W +: W])) begin
                    fwdSel_execute[i*2 +: 2] = FWD_WRITEBACK;
                end
            end
        end
    end

endmodule

// File: doc/jzjpcc_hazard_controller.md
Name: jzjpcc_hazard_controller

Overview:
Parametrised hazard controller for the jzjpcc pipeline (fetch, decode, execute, memory, writeback).
- Produces forwarding selects for execute-stage operands.
- Detects load-use hazards and holds a multi-cycle load-use stall through a countdown counter.
- Tracks long-latency (mul/div) destination registers in a busy-bit scoreboard.
- Applies data-memory wait stalls and branch/jump redirect flushes with fixed priority.

Parameters:
- REG_ADDR_WIDTH, 5, register address width; register file has 2**REG_ADDR_WIDTH entries, address 0 hardwired zero.
- NUM_SRC, 2, source operands per instruction.
- LOAD_USE_STALLS, 1, stall cycles inserted per load-use hazard (1..7).

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- rsAddr_decode  in  NUM_SRC*REG_ADDR_WIDTH  decode source addresses; src i at bits [i*W +: W].
- rsUsed_decode  in  NUM_SRC  source i actually read.
- rsAddr_execute  in  NUM_SRC*REG_ADDR_WIDTH  execute source addresses.
- rdAddr_execute / rdAddr_memory / rdAddr_writeback  in  REG_ADDR_WIDTH each  destination per stage.
- regWrite_execute / regWrite_memory / regWrite_writeback  in  1 each  stage writes rd.
- isLoad_execute  in  1  execute instruction is a load.
- longOpIssue_execute  in  1  execute instruction dispatches to the long-latency unit this cycle.
- longOpDone  in  1  long-latency unit completes this cycle.
- longOpDoneRd  in  REG_ADDR_WIDTH  completion destination.
- memBusy  in  1  data memory not ready.
- redirect_execute  in  1  taken branch/jump resolved in execute.
- stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  hold stage register.
- flush_decode, flush_execute, flush_memory  out  1 each  load bubble into stage register.
- fwdSel_execute  out  NUM_SRC*2  per-source fwd_sel_t.
- loadUseCount  out  3  remaining load-use stall cycles (debug/verification).

Behaviour:
- Reset (async): scoreboard cleared, counter 0. While reset is high: stalls 0, flushes 1, fwdSel FWD_NONE.
- Forwarding (combinational), per source i with address ≠ 0:
  - FWD_MEMORY if regWrite_memory and rdAddr_memory match.
  - Else FWD_WRITEBACK if regWrite_writeback and rdAddr_writeback match.
  - Else FWD_NONE. Memory has priority over writeback.
- Load-use detect: isLoad_execute && regWrite_execute && rdAddr_execute≠0 && some used decode source equals rdAddr_execute.
- Scoreboard hazard: some used decode source ≠0 has its busy bit set.
- Counter:
  - On load-use detect with count==0 and no memBusy/redirect, load LOAD_USE_STALLS-1 next edge.
  - While count>0 and no memBusy, decrement.
  - memBusy freezes the counter.
  - Redirect clears it to 0.
- Load-use stall active = detect || count>0.
- Scoreboard:
  - Busy[rd] set on longOpIssue_execute && regWrite_execute && rd≠0 && !memBusy && !redirect.
  - Busy[longOpDoneRd] cleared on longOpDone, accepted even during memBusy.
  - Same-cycle set and clear of the same register: set wins.
  - Clear of a non-busy register is ignored.
  - Register 0 is never busy.
- Priority, highest first:
  1. memBusy: stall fetch, decode, execute and memory; no flushes.
  2. redirect_execute: flush_decode=1, flush_execute=1; no stalls.
  3. Load-use or scoreboard hazard: stall_fetch=1, stall_decode=1, flush_execute=1.
  4. Otherwise all 0.
- flush_memory is asserted only during reset.
- Scoreboard hazard holds decode indefinitely until the busy bit clears. It is not counted.

Decomposition:
- Package jzjpcc_hazard_pkg:
  - fwd_sel_t enum: FWD_NONE=0, FWD_MEMORY=1, FWD_WRITEBACK=2.
  - Constant ZERO_REG=0.
  - Stall/flush bundle struct.
- Sub-module jzjpcc_scoreboard (busy vector, set/clear ports, NUM_SRC lookup).
- Priority logic and counter stay in the top module.

Test Plan:
- Forwarding:
  - add x5 in memory and add x5 in writeback, execute reads rs1=x5 → fwdSel src0=FWD_MEMORY.
  - Only writeback writes x5 → FWD_WRITEBACK.
  - rs=x0 with rd=x0 writes → FWD_NONE.
- Load-use: lw x7 in execute, decode reads x7, LOAD_USE_STALLS=3 → stall_fetch/decode high exactly 3 cycles with flush_execute high; loadUseCount 2,1,0; then release.
- Scoreboard:
  - div x9 issued, decode reads x9 → stalled.
  - Issue x9 and longOpDone rd=x9 in same cycle → busy stays set.
  - Later longOpDone rd=x9 → stall drops next cycle.
- memBusy held 4 cycles during a load-use countdown → all stalls high, counter frozen; countdown resumes afterwards.
- Redirect during load-use stall → flush_decode=flush_execute=1, stalls 0, counter cleared to 0.
- Reset asserted mid-countdown with x3, x4 busy → immediate flush outputs 1, stall outputs 0, counter 0, scoreboard empty after release.
